logic_result_checker: RTL

Sequential response checker for the 32-bit logic unit. It accepts a stream of operand/select/result tuples over a valid/ready handshake and compares each observed result against a golden bitwise function. It counts vectors and mismatches, captures the first failure, and reports pass/done at the end of a run of programmed length. It sits on the result side of the logic unit: stimulus is driven into the unit, and this block consumes and judges what comes out.

---
 rtl/logic_chk_pkg.sv | 34 +++
 rtl/logic_result_checker_if.sv | 14 +
 rtl/logic_chk_stage.sv | 101 ++++++++++
 rtl/logic_result_checker.sv | 102 ++++++++++
 4 files changed

// File: rtl/logic_chk_pkg.sv
// Shared definitions for the logic-unit result checker: select codes, FSM states, golden function.
package logic_chk_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_AND = 2'b00;
    localparam sel_t SEL_OR  = 2'b01;
    localparam sel_t SEL_XOR = 2'b10;
    localparam sel_t SEL_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Reference behaviour of the logic unit for one operand pair.
    function automatic logic [DATA_W-1:0] logic_golden(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input sel_t              sel
    );
        case (sel)
            SEL_AND: return a & b;
            SEL_OR:  return a | b;
            SEL_XOR: return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

endpackage

// File: rtl/logic_result_checker_if.sv
// Tuple stream from the logic unit into the checker: operands, select and observed result.
interface logic_result_checker_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic [WIDTH-1:0] r;

    modport master (output in_valid, a, b, sel, r, input in_ready);
    modport slave  (input in_valid, a, b, sel, r, output in_ready);
endinterface

// File: rtl/logic_chk_stage.sv
// One-entry compare stage with saturating vector/error counters and first-failure capture.
module logic_chk_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] exp_i,
    input  logic [WIDTH-1:0] got_i,
    input  logic [CNT_W-1:0] idx_i,
    output logic [CNT_W-1:0] vec_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] ff_idx_o,
    output logic [WIDTH-1:0] ff_exp_o,
    output logic [WIDTH-1:0] ff_got_o
);

    logic             valid_q;
    logic [WIDTH-1:0] exp_q, got_q;
    logic [CNT_W-1:0] idx_q;

    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             have_fail_q, have_fail_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [WIDTH-1:0] ff_exp_q, ff_exp_d;
    logic [WIDTH-1:0] ff_got_q, ff_got_d;
    logic             mismatch_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Counter and first-failure update from the staged compare; clear wins.
    always_comb begin
        vec_d       = vec_q;
        err_d       = err_q;
        have_fail_d = have_fail_q;
        ff_idx_d    = ff_idx_q;
        ff_exp_d    = ff_exp_q;
        ff_got_d    = ff_got_q;
        mismatch_c  = valid_q && (exp_q != got_q);
        if (clear_i) begin
            vec_d       = '0;
            err_d       = '0;
            have_fail_d = 1'b0;
            ff_idx_d    = '0;
            ff_exp_d    = '0;
            ff_got_d    = '0;
        end else if (valid_q) begin
            vec_d = sat_inc(vec_q);
            if (mismatch_c) begin
                err_d       = sat_inc(err_q);
                have_fail_d = 1'b1;
                if (!have_fail_q) begin
                    ff_idx_d = idx_q;
                    ff_exp_d = exp_q;
                    ff_got_d = got_q;
                end
            end
        end
    end

    // Stage register and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            exp_q       <= '0;
            got_q       <= '0;
            idx_q       <= '0;
            vec_q       <= '0;
            err_q       <= '0;
            have_fail_q <= 1'b0;
            ff_idx_q    <= '0;
            ff_exp_q    <= '0;
            ff_got_q    <= '0;
        end else begin
            valid_q <= load_i && !clear_i;
            if (load_i) begin
                exp_q <= exp_i;
                got_q <= got_i;
                idx_q <= idx_i;
            end
            vec_q       <= vec_d;
            err_q       <= err_d;
            have_fail_q <= have_fail_d;
            ff_idx_q    <= ff_idx_d;
            ff_exp_q    <= ff_exp_d;
            ff_got_q    <= ff_got_d;
        end
    end

    assign vec_count_o = vec_q;
    assign err_count_o = err_q;
    assign ff_idx_o    = ff_idx_q;
    assign ff_exp_o    = ff_exp_q;
    assign ff_got_o    = ff_got_q;

endmodule

// File: rtl/logic_result_checker.sv
// Run-level control for the logic-unit result checker: FSM, handshake and run length.
module logic_result_checker
    import logic_chk_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vectors,
    logic_result_checker_if.slave  bus,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       vec_count,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       first_fail_idx,
    output logic [WIDTH-1:0]       first_fail_exp,
    output logic [WIDTH-1:0]       first_fail_got
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             ready_q;
    logic             done_q;
    logic             clear_c;
    logic             accept_c;
    logic [WIDTH-1:0] exp_c;

    assign accept_c = bus.in_valid && ready_q;
    assign exp_c    = WIDTH'(logic_golden(DATA_W'(bus.a), DATA_W'(bus.b), bus.sel));

    // Next-state, run-length latch and accept index.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        clear_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear_c = 1'b1;
                    num_d   = num_vectors;
                    idx_d   = '0;
                    state_d = (num_vectors == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    idx_d = idx_q + CNT_W'(1);
                    if (idx_q == num_q - CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // State register with registered ready/done decodes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            ready_q <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    logic_chk_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_c),
        .load_i      (accept_c),
        .exp_i       (exp_c),
        .got_i       (bus.r),
        .idx_i       (idx_q),
        .vec_count_o (vec_count),
        .err_count_o (err_count),
        .ff_idx_o    (first_fail_idx),
        .ff_exp_o    (first_fail_exp),
        .ff_got_o    (first_fail_got)
    );

    assign bus.in_ready = ready_q;
    assign done         = done_q;
    assign pass         = done_q && (err_count == '0);

endmodule
